// File: rtl/cnn_conv2_pkg.sv
// Shared constants and types for the conv2 MAC accumulator and its requantizer.
package cnn_conv2_pkg;

  localparam int unsigned PROD_W = 23;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned TAPS   = 150;
  localparam int unsigned BIAS_W = 16;
  localparam int unsigned SHIFT  = 8;
  localparam int unsigned OUT_W  = 14;
  localparam int unsigned TAP_W  = $clog2(TAPS);

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  act_t;
  typedef logic signed [BIAS_W-1:0] bias_t;
  typedef logic        [TAP_W-1:0]  tap_t;

  localparam act_t SAT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam act_t SAT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam tap_t TAP_LAST = tap_t'(TAPS - 1);

  // Sign-extend a product to accumulator width.
  function automatic acc_t sext_prod(input prod_t p);
    return acc_t'(p);
  endfunction

  // Sign-extend a bias to accumulator width.
  function automatic acc_t sext_bias(input bias_t b);
    return acc_t'(b);
  endfunction

endpackage

// File: rtl/cnn_conv2_requant.sv
// Combinational requantizer: round-half-up, arithmetic right shift, saturate to OUT_W.
// CNN_CONV2_ACC_RELU_EN: when defined, negative saturated results are clamped to zero.
module cnn_conv2_requant
  import cnn_conv2_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [OUT_W-1:0] act_c
);

  localparam acc_t RND     = acc_t'(1) <<< (SHIFT - 1);
  localparam acc_t MAX_ACC = acc_t'(SAT_MAX);
  localparam acc_t MIN_ACC = acc_t'(SAT_MIN);

  acc_t rounded;
  acc_t shifted;

  // Round, shift and clamp the full-precision window sum to the activation range.
  always_comb begin
    rounded = acc_in + RND;
    shifted = rounded >>> SHIFT;
    act_c   = act_t'(shifted);
    if (shifted > MAX_ACC) begin
      act_c = SAT_MAX;
    end else if (shifted < MIN_ACC) begin
      act_c = SAT_MIN;
    end
`ifdef CNN_CONV2_ACC_RELU_EN
    if (act_c[OUT_W-1]) begin
      act_c = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/cnn_conv2_mac_accum.sv
// conv2 accumulator: sums TAPS products per pixel plus bias, requantizes, emits one activation.
// CNN_CONV2_ACC_RELU_EN: enables ReLU clamping inside the requantizer.
module cnn_conv2_mac_accum
  import cnn_conv2_pkg::*;
(
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [PROD_W-1:0] prod_data,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [TAP_W-1:0]  tap_idx
);

  if (ACC_W < PROD_W + $clog2(TAPS) + 1) begin : g_acc_w_check
    $error("cnn_conv2_mac_accum: ACC_W too narrow for PROD_W and TAPS");
  end

  acc_t acc;
  acc_t base;
  acc_t sum;
  act_t act;
  logic last;
  logic accept;

  // Ready only blocks the closing tap while a finished pixel is still waiting downstream.
  always_comb begin
    last       = (tap_idx == TAP_LAST);
    prod_ready = !ap_rst && !(last && out_valid && !out_ready);
    accept     = prod_valid && prod_ready;
    base       = (tap_idx == '0) ? sext_bias(bias) : acc;
    sum        = base + sext_prod(prod_data);
  end

  cnn_conv2_requant u_requant (
    .acc_in (sum),
    .act_c  (act)
  );

  // Tap counter and running window sum.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tap_idx <= '0;
      acc     <= '0;
    end else if (accept) begin
      acc     <= sum;
      tap_idx <= last ? '0 : tap_idx + tap_t'(1);
    end
  end

  // Output holding register: loads on closing tap, clears on drain unless reloaded.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (accept && last) begin
      out_data  <= act;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_conv2_mac_accum.sv
// Self-checking bench for cnn_conv2_mac_accum using an arithmetic reference model.
module tb_cnn_conv2_mac_accum;
  import cnn_conv2_pkg::*;

  logic  ap_clk = 1'b0;
  logic  ap_rst;
  prod_t prod_data;
  logic  prod_valid;
  logic  prod_ready;
  bias_t bias;
  act_t  out_data;
  logic  out_valid;
  logic  out_ready;
  tap_t  tap_idx;

  int     checks = 0;
  int     errors = 0;
  int     stall_cycles = 0;
  longint cyc = 0;
  bit     rnd_done = 1'b0;
  act_t   obs_q[$];
  longint obs_cyc[$];

  cnn_conv2_mac_accum dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .bias       (bias),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .tap_idx    (tap_idx)
  );

  always #5 ap_clk = ~ap_clk;

  // Record every output handshake and the cycle it happened in.
  always @(posedge ap_clk) begin
    cyc = cyc + 1;
    if (!ap_rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      obs_q.push_back(out_data);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic longint floor_div(input longint n, input longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // Reference: exact window sum -> round-half-up divide by 2^SHIFT -> clamp (-> ReLU).
  function automatic int model(input longint r);
    longint y, hi, lo;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    y  = floor_div(r + (longint'(1) << (SHIFT - 1)), longint'(1) << SHIFT);
    if (y > hi) y = hi;
    if (y < lo) y = lo;
`ifdef CNN_CONV2_ACC_RELU_EN
    if (y < 0) y = 0;
`endif
    return int'(y);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  // Offer one product; returns one cycle after it is accepted.
  task automatic send(input prod_t p, input bias_t b);
    int n = 0;
    prod_data  = p;
    bias       = b;
    prod_valid = 1'b1;
    @(negedge ap_clk);
    while (prod_ready !== 1'b1 && n < 1000) begin
      stall_cycles++;
      @(negedge ap_clk);
      n++;
    end
    if (prod_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: prod_ready=%b expected 1", prod_ready);
    end
    @(posedge ap_clk);
    #1;
    prod_valid = 1'b0;
    prod_data  = prod_t'($urandom);
    bias       = bias_t'($urandom);
  endtask

  // Drive one full window; mode 0 = constant val, mode 1 = uniform in [-val, val].
  task automatic run_window(input int b, input int mode, input int val, input int gap_pct,
                            output longint r);
    int p;
    r = longint'(b);
    for (int i = 0; i < int'(TAPS); i++) begin
      if (mode == 0) p = val;
      else p = int'($urandom_range(32'(2 * val))) - val;
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle(1);
      send(prod_t'(p), (i == 0) ? bias_t'(b) : bias_t'($urandom));
      r += longint'(p);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; prod_valid = 1'b1; prod_data = prod_t'(5); bias = '0; out_ready = 1'b1;
    idle(3);
    checks++; if (tap_idx !== '0) begin errors++; $display("FAIL reset_tap_idx: got %0d expected 0", tap_idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    checks++; if (prod_ready !== 1'b0) begin errors++; $display("FAIL reset_prod_ready: got %b expected 0", prod_ready); end
    ap_rst = 1'b0; prod_valid = 1'b0;
    idle(1);
    checks++; if (prod_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", prod_ready); end
  endtask

  task automatic test_basic();
    longint r;
    out_ready = 1'b1; idle(3); obs_q.delete(); obs_cyc.delete();
    run_window(0, 0, 256, 0, r);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== act_t'(150)) begin errors++; $display("FAIL basic_data: got %0d expected 150", out_data); end
    checks++; if (tap_idx !== '0) begin errors++; $display("FAIL basic_tap_wrap: got %0d expected 0", tap_idx); end
    idle(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clear: got %b expected 0", out_valid); end
  endtask

  task automatic test_saturate();
    longint r;
    int e;
    out_ready = 1'b1;
    run_window(32767, 0, 4194303, 0, r); e = model(r);
    checks++; if (out_data !== act_t'(e)) begin errors++; $display("FAIL sat_pos: got %0d expected %0d", out_data, e); end
    run_window(-32768, 0, -4194304, 0, r); e = model(r);
    checks++; if (out_data !== act_t'(e)) begin errors++; $display("FAIL sat_neg: got %0d expected %0d", out_data, e); end
    run_window(0, 0, -256, 0, r); e = model(r);
    checks++; if (out_data !== act_t'(e)) begin errors++; $display("FAIL neg_small: got %0d expected %0d", out_data, e); end
  endtask

  task automatic test_rounding();
    int bvals[4];
    longint r;
    int e;
    bvals[0] = 128; bvals[1] = 127; bvals[2] = -128; bvals[3] = -129;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_window(bvals[k], 0, 0, 0, r); e = model(r);
      checks++;
      if (out_data !== act_t'(e)) begin
        errors++; $display("FAIL round_r%0d: got %0d expected %0d", bvals[k], out_data, e);
      end
    end
  endtask

  task automatic test_random();
    longint r;
    int exp_q[$];
    int n = 0;
    idle(3); obs_q.delete(); obs_cyc.delete();
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge ap_clk); #1;
          out_ready = 1'($urandom_range(1));
        end
      end
    join_none
    for (int w = 0; w < 6; w++) begin
      run_window(int'($urandom_range(65535)) - 32768, 1, (w < 3) ? 20000 : 4194303, 20, r);
      exp_q.push_back(model(r));
    end
    rnd_done = 1'b1;
    idle(3);
    out_ready = 1'b1;
    while (obs_q.size() < 6 && n < 2000) begin @(posedge ap_clk); n++; end
    #1;
    checks++;
    if (obs_q.size() != 6) begin errors++; $display("FAIL random_count: got %0d expected 6", obs_q.size()); end
    for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== act_t'(exp_q[k])) begin
        errors++; $display("FAIL random_win%0d: got %0d expected %0d", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_stall();
    longint r, r2;
    int p, e2, s0;
    idle(3); out_ready = 1'b0;
    run_window(0, 0, 256, 0, r);
    obs_q.delete(); obs_cyc.delete();
    s0 = stall_cycles;
    r2 = longint'(-1000);
    for (int i = 0; i < int'(TAPS) - 1; i++) begin
      p = int'($urandom_range(2000000)) - 1000000;
      send(prod_t'(p), (i == 0) ? bias_t'(-1000) : bias_t'($urandom));
      r2 += longint'(p);
    end
    checks++; if (stall_cycles != s0) begin errors++; $display("FAIL stall_early_taps: stalls %0d expected 0", stall_cycles - s0); end
    p = 777777; r2 += longint'(p); e2 = model(r2);
    prod_data = prod_t'(p); bias = bias_t'($urandom); prod_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      checks++; if (prod_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_c%0d: got %b expected 0", k, prod_ready); end
      checks++; if (out_data !== act_t'(150) || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold_c%0d: got %0d/%b expected 150/1", k, out_data, out_valid); end
    end
    checks++; if (tap_idx !== TAP_LAST) begin errors++; $display("FAIL stall_tap: got %0d expected %0d", tap_idx, TAPS - 1); end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    prod_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== act_t'(e2)) begin
      errors++; $display("FAIL stall_reload: got %0d/%b expected %0d/1", out_data, out_valid, e2); end
    checks++; if (obs_q.size() != 1 || obs_q[0] !== act_t'(150)) begin
      errors++; $display("FAIL stall_drain: got %0d items expected 1 of 150", obs_q.size()); end
    idle(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    longint r;
    int exp_q[$];
    int s0;
    out_ready = 1'b1; idle(3); obs_q.delete(); obs_cyc.delete();
    s0 = stall_cycles;
    for (int w = 0; w < 3; w++) begin
      run_window(int'($urandom_range(65535)) - 32768, 1, 4194303, 0, r);
      exp_q.push_back(model(r));
    end
    idle(2);
    checks++; if (stall_cycles != s0) begin errors++; $display("FAIL b2b_stalls: got %0d expected 0", stall_cycles - s0); end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== act_t'(exp_q[k])) begin
        errors++; $display("FAIL b2b_win%0d: got %0d expected %0d", k, obs_q[k], exp_q[k]);
      end
    end
    for (int k = 1; k < 3 && k < obs_cyc.size(); k++) begin
      checks++;
      if (obs_cyc[k] - obs_cyc[k-1] != longint'(TAPS)) begin
        errors++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", k, obs_cyc[k] - obs_cyc[k-1], TAPS);
      end
    end
  endtask

  task automatic test_reset_mid();
    longint r;
    int e;
    idle(2); out_ready = 1'b0;
    run_window(0, 0, 256, 0, r);
    for (int i = 0; i < 70; i++) send(prod_t'(256), bias_t'(100));
    checks++; if (tap_idx !== tap_t'(70) || out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got tap %0d valid %b expected 70/1", tap_idx, out_valid); end
    ap_rst = 1'b1;
    idle(1);
    checks++; if (out_valid !== 1'b0 || tap_idx !== '0) begin
      errors++; $display("FAIL midrst_clear: got valid %b tap %0d expected 0/0", out_valid, tap_idx); end
    ap_rst = 1'b0; out_ready = 1'b1;
    run_window(512, 0, 256, 0, r); e = model(r);
    checks++; if (out_data !== act_t'(152) || e != 152) begin
      errors++; $display("FAIL midrst_fresh: got %0d (model %0d) expected 152", out_data, e); end
  endtask

  initial begin
    ap_rst = 1'b1; prod_valid = 1'b0; prod_data = '0; bias = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_rounding();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
